// File: rtl/ir_queue.sv
// Instruction register queue: circular buffer between fetch and decode.
// The head entry is presented on out1 with its opcode/operand fields split out.
module ir_queue #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int OPC_W = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in1,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       adv,
  input  logic                       flush,
  output logic [WIDTH-1:0]           out1,
  output logic                       ir_valid,
  output logic [OPC_W-1:0]           opcode,
  output logic [WIDTH-OPC_W-1:0]     operand,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_load;
  logic             do_cons;

  assign in_ready = (count < FULL);
  assign ir_valid = (count != '0);
  assign do_load  = in_valid && in_ready;
  assign do_cons  = adv && ir_valid;

  // DEPTH is a power of two, so pointer wrap falls out of the natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (do_load) wr_ptr <= wr_ptr + PW'(1);
      if (do_cons) rd_ptr <= rd_ptr + PW'(1);
      case ({do_load, do_cons})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (adv && !ir_valid) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_load && !flush) mem[wr_ptr] <= in1;
  end

  assign out1    = ir_valid ? mem[rd_ptr] : '0;
  assign opcode  = out1[WIDTH-1 -: OPC_W];
  assign operand = out1[WIDTH-OPC_W-1:0];

endmodule

// File: tb/tb_ir_queue.sv
// Directed bench for ir_queue with default parameters (WIDTH=4, DEPTH=4, OPC_W=2).
// Inputs change just after each rising edge; outputs are checked before the next one.
module tb_ir_queue;

  logic       clk;
  logic       rst_n;
  logic [3:0] in1;
  logic       in_valid;
  logic       in_ready;
  logic       adv;
  logic       flush;
  logic [3:0] out1;
  logic       ir_valid;
  logic [1:0] opcode;
  logic [1:0] operand;
  logic [2:0] count;
  logic       err;

  int checks = 0;
  int fails  = 0;

  ir_queue #(.WIDTH(4), .DEPTH(4), .OPC_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in1(in1), .in_valid(in_valid), .in_ready(in_ready),
    .adv(adv), .flush(flush), .out1(out1), .ir_valid(ir_valid), .opcode(opcode),
    .operand(operand), .count(count), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] d, input logic a, input logic f);
    in_valid = v;
    in1      = d;
    adv      = a;
    flush    = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    #3;
    checkOutput("rst_count", count, 0);
    checkOutput("rst_ir_valid", ir_valid, 0);
    checkOutput("rst_out1", out1, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_opcode", opcode, 0);
    checkOutput("rst_operand", operand, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single word 7: opcode 01, operand 11
    applyStimulus(1'b1, 4'd7, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("one_out1", out1, 7);
    checkOutput("one_opcode", opcode, 1);
    checkOutput("one_operand", operand, 3);
    checkOutput("one_ir_valid", ir_valid, 1);
    checkOutput("one_count", count, 1);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("one_drained", count, 0);

    // Fill to full, then try to push 5
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);
      tick();
    end
    checkOutput("full_count", count, 4);
    checkOutput("full_in_ready", in_ready, 0);
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0);
    tick();
    checkOutput("full_reject_count", count, 4);
    checkOutput("full_head", out1, 1);
    applyStimulus(1'b1, 4'd5, 1'b1, 1'b0);
    tick();
    checkOutput("full_cons_count", count, 3);
    checkOutput("full_cons_head", out1, 2);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    for (int i = 2; i <= 4; i++) begin
      checkOutput("drain_seq", out1, i);
      tick();
    end
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("drain_ir_valid", ir_valid, 0);
    checkOutput("drain_out1", out1, 0);
    checkOutput("drain_err", err, 0);

    // Three entries, then six cycles of load+consume across the wrap
    for (int i = 10; i <= 12; i++) begin
      applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);
      tick();
    end
    checkOutput("stream_fill", count, 3);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 4'(13 + k), 1'b1, 1'b0);
      checkOutput("stream_head", out1, 10 + k);
      tick();
      checkOutput("stream_count", count, 3);
    end
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checkOutput("stream_tail_valid", ir_valid, 1);
      checkOutput("stream_tail", out1, k);
      tick();
    end
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("stream_empty", count, 0);

    // Underflow sets a sticky error, flush clears it
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("uf_err", err, 1);
    checkOutput("uf_count", count, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("uf_sticky", err, 1);
    end
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("uf_flush_err", err, 0);

    // Flush beats a simultaneous load
    applyStimulus(1'b1, 4'd3, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0);
    tick();
    checkOutput("fl_pre_count", count, 2);
    applyStimulus(1'b1, 4'd9, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("fl_count", count, 0);
    checkOutput("fl_ir_valid", ir_valid, 0);
    checkOutput("fl_out1", out1, 0);
    tick();
    checkOutput("fl_no_9", count, 0);
    applyStimulus(1'b1, 4'd6, 1'b0, 1'b0);
    tick();
    checkOutput("fl_reload_head", out1, 6);
    checkOutput("fl_reload_count", count, 1);

    // Asynchronous reset between edges with three words queued
    applyStimulus(1'b1, 4'd2, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd4, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("ar_pre_count", count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_count", count, 0);
    checkOutput("ar_ir_valid", ir_valid, 0);
    checkOutput("ar_out1", out1, 0);
    checkOutput("ar_in_ready", in_ready, 1);
    applyStimulus(1'b1, 4'd11, 1'b1, 1'b0);
    tick();
    checkOutput("ar_hold_count", count, 0);
    checkOutput("ar_hold_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'd8, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("ar_first_load", out1, 8);
    checkOutput("ar_first_count", count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
